// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: state and coin encodings,
// credit/product-index widths and the greedy coin helpers.
package vend_pkg;

  localparam int CRED_W = 8;
  localparam int IDX_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    COIN_1  = 2'd0,
    COIN_5  = 2'd1,
    COIN_10 = 2'd2
  } coin_t;

  localparam logic [CRED_W-1:0] COIN_1_VAL  = 8'd1;
  localparam logic [CRED_W-1:0] COIN_5_VAL  = 8'd5;
  localparam logic [CRED_W-1:0] COIN_10_VAL = 8'd10;

  function automatic coin_t greedy_coin(input logic [CRED_W-1:0] v);
    coin_t c;
    if (v >= COIN_10_VAL) begin
      c = COIN_10;
    end else if (v >= COIN_5_VAL) begin
      c = COIN_5;
    end else begin
      c = COIN_1;
    end
    return c;
  endfunction

  function automatic logic [CRED_W-1:0] coin_value(input coin_t c);
    logic [CRED_W-1:0] v;
    case (c)
      COIN_1:  v = COIN_1_VAL;
      COIN_5:  v = COIN_5_VAL;
      COIN_10: v = COIN_10_VAL;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_change.sv
// Change payout engine: holds the remaining change and emits greedy coin pulses
// spaced by CHG_GAP cycles; done pulses alongside the coin that empties the balance.
module vend_change
  import vend_pkg::*;
#(
  parameter int CHG_GAP = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [CRED_W-1:0] load_val_i,
  input  logic              start_i,
  output logic              chg_vld_o,
  output logic [1:0]        chg_coin_o,
  output logic              done_o
);

  localparam int GAP_W = $clog2(CHG_GAP);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(CHG_GAP - 1);

  logic [CRED_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              active_q, active_d;
  logic              vld_q, vld_d;
  coin_t             coin_q, coin_d;
  logic              done_q, done_d;

  logic [CRED_W-1:0] eff_s;
  coin_t             coin_s;
  logic              fire_s;

  // Next-state: a start (possibly with a same-cycle load) fires at once; later coins wait out the gap.
  always_comb begin
    eff_s    = load_i ? load_val_i : rem_q;
    coin_s   = greedy_coin(eff_s);
    if (start_i) begin
      fire_s = (eff_s != 8'd0);
    end else if (active_q) begin
      fire_s = (gap_q == GAP_W'(0)) && (rem_q != 8'd0);
    end else begin
      fire_s = 1'b0;
    end
    rem_d    = eff_s;
    gap_d    = gap_q;
    active_d = active_q;
    vld_d    = 1'b0;
    coin_d   = COIN_1;
    done_d   = 1'b0;
    if (fire_s) begin
      rem_d    = eff_s - coin_value(coin_s);
      gap_d    = GAP_RELOAD;
      vld_d    = 1'b1;
      coin_d   = coin_s;
      done_d   = (rem_d == 8'd0);
      active_d = (rem_d != 8'd0);
    end else if (active_q && (gap_q != GAP_W'(0))) begin
      gap_d = gap_q - GAP_W'(1);
    end else begin
      gap_d = gap_q;
    end
  end

  // Payout state and registered coin strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q    <= 8'd0;
      gap_q    <= GAP_W'(0);
      active_q <= 1'b0;
      vld_q    <= 1'b0;
      coin_q   <= COIN_1;
      done_q   <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      active_q <= active_d;
      vld_q    <= vld_d;
      coin_q   <= coin_d;
      done_q   <= done_d;
    end
  end

  assign chg_vld_o  = vld_q;
  assign chg_coin_o = coin_q;
  assign done_o     = done_q;

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine sequencer: decodes select/cancel/timeout in IDLE, strobes the dispense,
// clears the money block and hands the change balance to vend_change for payout.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE0      = 15,
  parameter int PRICE1      = 25,
  parameter int PRICE2      = 30,
  parameter int PRICE3      = 50,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CHG_GAP     = 4
) (
  input  logic       sclk,
  input  logic       srst_n,
  input  logic [3:0] sel,
  input  logic       cancel,
  input  logic [7:0] money_val,
  input  logic       money_flag,
  output logic       money_en,
  output logic       money_clr,
  output logic       disp_vld,
  output logic [1:0] disp_idx,
  output logic       short_err,
  output logic       chg_vld,
  output logic [1:0] chg_coin,
  output logic       busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t            state_q;
  logic              money_en_q, money_clr_q, disp_vld_q, short_err_q, busy_q, vend_chg_q;
  logic [IDX_W-1:0]  disp_idx_q;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic              sel_any_s, sel_onehot_s, credit_nz_s, to_clr_s, to_fire_s;
  logic [IDX_W-1:0]  sel_idx_s;
  logic [CRED_W-1:0] price_s, vend_rem_s, chg_val_s;
  logic              act_refund_s, act_vend_s, act_short_s;
  logic              chg_load_s, chg_start_s, chg_done_s;

  // Front-panel decode; cancel outranks select, which outranks the idle timeout.
  always_comb begin
    sel_any_s    = (sel != 4'd0);
    sel_onehot_s = sel_any_s && ((sel & (sel - 4'd1)) == 4'd0);
    case (sel)
      4'b0001: sel_idx_s = 2'd0;
      4'b0010: sel_idx_s = 2'd1;
      4'b0100: sel_idx_s = 2'd2;
      4'b1000: sel_idx_s = 2'd3;
      default: sel_idx_s = 2'd0;
    endcase
    case (sel_idx_s)
      2'd0:    price_s = CRED_W'(PRICE0);
      2'd1:    price_s = CRED_W'(PRICE1);
      2'd2:    price_s = CRED_W'(PRICE2);
      2'd3:    price_s = CRED_W'(PRICE3);
      default: price_s = CRED_W'(PRICE0);
    endcase
    vend_rem_s   = money_val - price_s;
    credit_nz_s  = (money_val != 8'd0);
    to_clr_s     = money_flag || sel_any_s || cancel || !credit_nz_s;
    to_fire_s    = !to_clr_s && (to_cnt_q == TO_LAST);
    act_refund_s = (cancel && credit_nz_s) || to_fire_s;
    act_vend_s   = !cancel && sel_onehot_s && (money_val >= price_s);
    act_short_s  = !cancel && sel_any_s && !act_vend_s;
  end

  // Payout handshake: a refund loads and starts together, a vend loads now and starts from VEND.
  always_comb begin
    chg_load_s  = 1'b0;
    chg_start_s = 1'b0;
    chg_val_s   = vend_rem_s;
    if (state_q == ST_IDLE) begin
      if (act_refund_s) begin
        chg_load_s  = 1'b1;
        chg_start_s = 1'b1;
        chg_val_s   = money_val;
      end else if (act_vend_s) begin
        chg_load_s  = 1'b1;
      end else begin
        chg_load_s  = 1'b0;
      end
    end else if (state_q == ST_VEND) begin
      chg_start_s = vend_chg_q;
    end else begin
      chg_start_s = 1'b0;
    end
  end

  // Idle-credit timeout: runs only in IDLE while credit sits untouched.
  always_comb begin
    if ((state_q != ST_IDLE) || to_clr_s || to_fire_s) begin
      to_cnt_d = TO_W'(0);
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Timeout counter register.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      to_cnt_q <= TO_W'(0);
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  // Main sequencer with registered panel/money/dispense outputs.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q     <= ST_IDLE;
      money_en_q  <= 1'b1;
      money_clr_q <= 1'b0;
      disp_vld_q  <= 1'b0;
      disp_idx_q  <= 2'd0;
      short_err_q <= 1'b0;
      busy_q      <= 1'b0;
      vend_chg_q  <= 1'b0;
    end else begin
      money_clr_q <= 1'b0;
      disp_vld_q  <= 1'b0;
      disp_idx_q  <= 2'd0;
      short_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (act_refund_s) begin
            state_q     <= ST_CHANGE;
            money_clr_q <= 1'b1;
            money_en_q  <= 1'b0;
            busy_q      <= 1'b1;
          end else if (act_vend_s) begin
            state_q     <= ST_VEND;
            money_clr_q <= 1'b1;
            disp_vld_q  <= 1'b1;
            disp_idx_q  <= sel_idx_s;
            money_en_q  <= 1'b0;
            busy_q      <= 1'b1;
            vend_chg_q  <= (vend_rem_s != 8'd0);
          end else begin
            state_q     <= ST_IDLE;
            short_err_q <= act_short_s;
            money_en_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        ST_VEND: begin
          if (vend_chg_q) begin
            state_q    <= ST_CHANGE;
            money_en_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= ST_IDLE;
            money_en_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        ST_CHANGE: begin
          if (chg_done_s) begin
            state_q    <= ST_IDLE;
            money_en_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            state_q    <= ST_CHANGE;
            money_en_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          money_en_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  vend_change #(
    .CHG_GAP (CHG_GAP)
  ) u_change (
    .clk_i      (sclk),
    .rst_ni     (srst_n),
    .load_i     (chg_load_s),
    .load_val_i (chg_val_s),
    .start_i    (chg_start_s),
    .chg_vld_o  (chg_vld),
    .chg_coin_o (chg_coin),
    .done_o     (chg_done_s)
  );

  assign money_en  = money_en_q;
  assign money_clr = money_clr_q;
  assign disp_vld  = disp_vld_q;
  assign disp_idx  = disp_idx_q;
  assign short_err = short_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: a queue-based behavioural model predicts every output
// each cycle; directed scenarios pin the model with literal coin sequences and timings.
module tb_vend_ctrl;

  localparam int TOUT = 1000;
  localparam int GAP  = 4;

  logic       sclk = 1'b0;
  logic       srst_n = 1'b0;
  logic [3:0] sel = 4'd0;
  logic       cancel = 1'b0;
  logic [7:0] money_val = 8'd0;
  logic       money_flag = 1'b0;
  logic       money_en, money_clr, disp_vld, short_err, chg_vld, busy;
  logic [1:0] disp_idx, chg_coin;

  vend_ctrl #(
    .PRICE0(15), .PRICE1(25), .PRICE2(30), .PRICE3(50),
    .TIMEOUT_CYC(TOUT), .CHG_GAP(GAP)
  ) dut (
    .sclk(sclk), .srst_n(srst_n), .sel(sel), .cancel(cancel),
    .money_val(money_val), .money_flag(money_flag),
    .money_en(money_en), .money_clr(money_clr), .disp_vld(disp_vld),
    .disp_idx(disp_idx), .short_err(short_err), .chg_vld(chg_vld),
    .chg_coin(chg_coin), .busy(busy)
  );

  always #5 sclk = ~sclk;

  typedef struct packed {
    logic       en;
    logic       clr;
    logic       disp;
    logic [1:0] idx;
    logic       serr;
    logic       cvld;
    logic [1:0] coin;
    logic       busy;
  } rec_t;

  rec_t exp_r;
  rec_t q[$];
  int   tcnt, cyc, n_chk, n_fail, serr_cnt;
  int   coin_log[$], coin_cyc[$], disp_log[$], disp_cyc[$], clr_cyc[$];

  function automatic int price(input int i);
    case (i)
      0: return 15;
      1: return 25;
      2: return 30;
      default: return 50;
    endcase
  endfunction

  function automatic rec_t idle_rec();
    rec_t r;
    r = '0;
    r.en = 1'b1;
    return r;
  endfunction

  function automatic rec_t busy_rec();
    rec_t r;
    r = '0;
    r.busy = 1'b1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Queue the output records of a greedy payout of val units.
  task automatic push_change(input int val, input bit first_clr);
    int coins[$];
    int v;
    rec_t r;
    v = val;
    while (v > 0) begin
      if (v >= 10) begin coins.push_back(2); v -= 10; end
      else if (v >= 5) begin coins.push_back(1); v -= 5; end
      else begin coins.push_back(0); v -= 1; end
    end
    for (int k = 0; k < coins.size(); k++) begin
      r = busy_rec();
      r.cvld = 1'b1;
      r.coin = 2'(coins[k]);
      r.clr  = first_clr && (k == 0);
      q.push_back(r);
      if (k < coins.size() - 1)
        for (int g = 1; g < GAP; g++) q.push_back(busy_rec());
    end
  endtask

  // Behavioural model: decides the next cycle's outputs from the inputs seen at this edge.
  task automatic model_update();
    rec_t nxt, v;
    int idx;
    if (!srst_n) begin
      q.delete(); tcnt = 0; exp_r = idle_rec();
      return;
    end
    if (exp_r.busy) begin
      tcnt = 0;
      exp_r = (q.size() > 0) ? q.pop_front() : idle_rec();
      return;
    end
    nxt = idle_rec();
    idx = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
    if (cancel) begin
      if (money_val != 0) push_change(int'(money_val), 1'b1);
    end else if (sel != 4'd0) begin
      if ($countones(sel) == 1 && int'(money_val) >= price(idx)) begin
        v = busy_rec(); v.clr = 1'b1; v.disp = 1'b1; v.idx = 2'(idx);
        q.push_back(v);
        if (int'(money_val) - price(idx) != 0) push_change(int'(money_val) - price(idx), 1'b0);
      end else begin
        nxt.serr = 1'b1;
      end
    end else if (money_val != 0 && !money_flag && tcnt == TOUT - 1) begin
      push_change(int'(money_val), 1'b1);
    end
    if (cancel || sel != 4'd0 || money_flag || money_val == 0) tcnt = 0;
    else tcnt++;
    if (q.size() > 0) begin exp_r = q.pop_front(); tcnt = 0; end
    else exp_r = nxt;
  endtask

  task automatic compare_cycle();
    chk("money_en",  money_en,  exp_r.en);
    chk("money_clr", money_clr, exp_r.clr);
    chk("disp_vld",  disp_vld,  exp_r.disp);
    if (exp_r.disp) chk("disp_idx", disp_idx, exp_r.idx);
    chk("short_err", short_err, exp_r.serr);
    chk("chg_vld",   chg_vld,   exp_r.cvld);
    if (exp_r.cvld) chk("chg_coin", chg_coin, exp_r.coin);
    chk("busy",      busy,      exp_r.busy);
    if (chg_vld)   begin coin_log.push_back(int'(chg_coin)); coin_cyc.push_back(cyc); end
    if (disp_vld)  begin disp_log.push_back(int'(disp_idx)); disp_cyc.push_back(cyc); end
    if (money_clr) clr_cyc.push_back(cyc);
    if (short_err) serr_cnt++;
  endtask

  task automatic step();
    @(posedge sclk);
    cyc++;
    model_update();
    @(negedge sclk);
    compare_cycle();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    coin_log.delete(); coin_cyc.delete(); disp_log.delete(); disp_cyc.delete();
    clr_cyc.delete(); serr_cnt = 0;
  endtask

  task automatic check_coins(input string nm, input int e[$]);
    chk({nm, "_ncoins"}, coin_log.size(), e.size());
    for (int k = 0; k < e.size() && k < coin_log.size(); k++) begin
      chk({nm, "_coin"}, coin_log[k], e[k]);
      if (k > 0) chk({nm, "_spacing"}, coin_cyc[k] - coin_cyc[k-1], GAP);
    end
  endtask

  initial begin
    int mark, fmark, r, r2;
    int e[$];
    exp_r = idle_rec();
    tcnt = 0; cyc = 0; n_chk = 0; n_fail = 0; serr_cnt = 0;
    @(negedge sclk);
    run(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_money_en", money_en, 1'b1);
    chk("rst_chg_coin", chg_coin, 2'd0);
    srst_n = 1'b1;
    run(2);

    // 40 credits buys product 1 (25): dispense next cycle, change 10 then 5.
    clear_logs();
    money_val = 8'd40; sel = 4'b0010; mark = cyc;
    step();
    sel = 4'd0; money_val = 8'd0;
    run(15);
    chk("A_ndisp", disp_log.size(), 1);
    if (disp_log.size() == 1) begin
      chk("A_idx", disp_log[0], 1);
      chk("A_latency", disp_cyc[0] - mark, 1);
    end
    chk("A_clr_cnt", clr_cyc.size(), 1);
    e = '{2, 1}; check_coins("A", e);
    if (coin_cyc.size() > 0) chk("A_first_coin", coin_cyc[0] - mark, 2);
    chk("A_idle", busy, 1'b0);

    // 20 credits for product 2 (30): short error only.
    clear_logs();
    money_val = 8'd20; sel = 4'b0100;
    step();
    sel = 4'd0; money_val = 8'd0;
    run(4);
    chk("B_serr", serr_cnt, 1);
    chk("B_ndisp", disp_log.size(), 0);
    chk("B_money_en", money_en, 1'b1);

    // Cancel with 7 credits: 5,1,1.
    clear_logs();
    money_val = 8'd7; cancel = 1'b1; mark = cyc;
    step();
    cancel = 1'b0; money_val = 8'd0;
    run(15);
    chk("C_clr_cnt", clr_cyc.size(), 1);
    if (clr_cyc.size() == 1) chk("C_clr_cyc", clr_cyc[0] - mark, 1);
    e = '{1, 0, 0}; check_coins("C", e);
    chk("C_idle", busy, 1'b0);

    // Idle refund of 12 credits, restarted by a coin-accepted pulse after 500 cycles.
    clear_logs();
    money_val = 8'd12;
    run(499);
    chk("D_early", clr_cyc.size(), 0);
    money_flag = 1'b1;
    step();
    money_flag = 1'b0; fmark = cyc;
    for (int i = 0; i < 1100 && clr_cyc.size() == 0; i++) step();
    money_val = 8'd0;
    chk("D_clr_cnt", clr_cyc.size(), 1);
    if (clr_cyc.size() == 1) chk("D_clr_cyc", clr_cyc[0] - fmark, TOUT);
    run(15);
    e = '{2, 0, 0}; check_coins("D", e);

    // Cancel beats a simultaneous select: 50 refunded as five tens.
    clear_logs();
    money_val = 8'd50; cancel = 1'b1; sel = 4'b1000;
    step();
    cancel = 1'b0; sel = 4'd0; money_val = 8'd0;
    run(25);
    chk("E_ndisp", disp_log.size(), 0);
    e = '{2, 2, 2, 2, 2}; check_coins("E", e);

    // Asynchronous reset during a payout drops the remaining change.
    clear_logs();
    money_val = 8'd50; cancel = 1'b1;
    step();
    cancel = 1'b0; money_val = 8'd0;
    chk("F_first_coin", coin_log.size(), 1);
    step();
    #2 srst_n = 1'b0;
    #1;
    chk("F_rst_busy", busy, 1'b0);
    chk("F_rst_en", money_en, 1'b1);
    chk("F_rst_chg_vld", chg_vld, 1'b0);
    chk("F_rst_clr", money_clr, 1'b0);
    q.delete(); exp_r = idle_rec(); tcnt = 0;
    step();
    srst_n = 1'b1;
    clear_logs();
    run(20);
    chk("F_no_coins", coin_log.size(), 0);

    // Two select bits at once: short error only.
    clear_logs();
    money_val = 8'd60; sel = 4'b0011;
    step();
    sel = 4'd0; money_val = 8'd0;
    run(3);
    chk("G_serr", serr_cnt, 1);
    chk("G_ndisp", disp_log.size(), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) money_val = 8'($urandom_range(0, 80));
      money_flag = ($urandom_range(0, 99) < 4);
      sel = 4'd0; cancel = 1'b0;
      r2 = int'($urandom_range(0, 99));
      if (r2 < 10) sel = 4'(4'b0001 << $urandom_range(0, 3));
      else if (r2 < 13) sel = 4'(4'b0011 << $urandom_range(0, 2));
      else if (r2 < 16) cancel = 1'b1;
      step();
    end
    sel = 4'd0; cancel = 1'b0; money_flag = 1'b0; money_val = 8'd0;
    run(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
